// File: rtl/freq_meter_pkg.sv
// rtl/freq_meter_pkg.sv - shared state encoding, default sizes and saturation helper for freq_meter
package freq_meter_pkg;

    // Default accumulator/result width and synchronizer depth
    localparam int CNT_W_DEF       = 32;
    localparam int SYNC_STAGES_DEF = 2;

    // Raw state codes, kept as plain constants so older code can still compare against them
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ARM   = 2'd1;
    localparam logic [1:0] ST_COUNT = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        ARM   = ST_ARM,
        COUNT = ST_COUNT
    } state_t;

    // All-ones value of a counter of the given width (widths up to 64 bits)
    function automatic logic [63:0] sat_value(input int width);
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < 64; i++) begin
            if (i < width) begin
                v[i] = 1'b1;
            end
        end
        return v;
    endfunction

endpackage

// File: rtl/freq_meter_sync_edge_det.sv
// rtl/freq_meter_sync_edge_det.sv - synchronizer chain plus edge detect; FREQ_METER_BOTH_EDGES_EN selects both-edge pulses
module sync_edge_det
    import freq_meter_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic edge_o
);

    // A chain shorter than two flops does not protect against metastability
    localparam int STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    logic [STAGES-1:0] sync_q;
    logic              prev_q;
    logic              sync_out;

    assign sync_out = sync_q[STAGES-1];

    // Shift the asynchronous input through the synchronizer chain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
        end
    end

    // Remember the previous synchronized level for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= sync_out;
        end
    end

    // One-cycle pulse on the selected transition(s) of the synchronized level
`ifdef FREQ_METER_BOTH_EDGES_EN
    always_comb begin
        edge_o = sync_out ^ prev_q;
    end
`else
    always_comb begin
        edge_o = sync_out & ~prev_q;
    end
`endif

endmodule

// File: rtl/freq_meter.sv
// rtl/freq_meter.sv - gated edge counter with valid/ready result port; FREQ_METER_BOTH_EDGES_EN counts both edges
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             tick,
    input  logic             sig_in,
    output logic [CNT_W-1:0] result,
    output logic             valid,
    input  logic             ready,
    output logic             overflow,
    output logic             dropped,
    output logic             busy
);

    localparam logic [CNT_W-1:0] SAT_VAL = CNT_W'(sat_value(CNT_W));

    state_t           state;
    logic [CNT_W-1:0] acc;
    logic             ovf;
    logic             edge_pulse;

    logic             at_max;
    logic [CNT_W-1:0] acc_inc;
    logic [CNT_W-1:0] count_now;
    logic             ovf_now;
    logic             load;

    sync_edge_det #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync_edge_det (
        .clk    (clk),
        .rst_n  (rst_n),
        .d      (sig_in),
        .edge_o (edge_pulse)
    );

    // Saturating next count, including an edge that lands on the closing tick
    always_comb begin
        at_max    = (acc == SAT_VAL);
        acc_inc   = at_max ? acc : acc + CNT_W'(1);
        count_now = edge_pulse ? acc_inc : acc;
        ovf_now   = ovf | (edge_pulse & at_max);
        load      = (state == COUNT) && en && tick;
    end

    // Window state machine and accumulator; a partial first window is never counted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            acc   <= '0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    acc <= '0;
                    ovf <= 1'b0;
                    if (en) begin
                        state <= ARM;
                    end
                end
                ARM: begin
                    acc <= '0;
                    ovf <= 1'b0;
                    if (!en) begin
                        state <= IDLE;
                    end else if (tick) begin
                        state <= COUNT;
                    end
                end
                COUNT: begin
                    if (!en) begin
                        state <= IDLE;
                        acc   <= '0;
                        ovf   <= 1'b0;
                    end else if (tick) begin
                        acc <= '0;
                        ovf <= 1'b0;
                    end else if (edge_pulse) begin
                        acc <= acc_inc;
                        ovf <= ovf_now;
                    end
                end
                default: begin
                    state <= IDLE;
                    acc   <= '0;
                    ovf   <= 1'b0;
                end
            endcase
        end
    end

    // Result register and handshake; an unconsumed result that gets replaced raises dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result   <= '0;
            overflow <= 1'b0;
            valid    <= 1'b0;
            dropped  <= 1'b0;
        end else begin
            if (load) begin
                result   <= count_now;
                overflow <= ovf_now;
                valid    <= 1'b1;
                if (valid && !ready) begin
                    dropped <= 1'b1;
                end
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
            if ((state == IDLE) && en) begin
                dropped <= 1'b0;
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_freq_meter.sv
// tb/tb_freq_meter.sv - directed self-checking bench for freq_meter (32-bit and 4-bit instances)
module tb_freq_meter;

`ifdef FREQ_METER_BOTH_EDGES_EN
    localparam int EM = 2;
`else
    localparam int EM = 1;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        tick;
    logic        sig_in;
    logic        ready;

    logic [31:0] result;
    logic        valid, overflow, dropped, busy;
    logic [3:0]  result4;
    logic        valid4, overflow4, dropped4, busy4;

    freq_meter #(.CNT_W(32), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .tick(tick), .sig_in(sig_in),
        .result(result), .valid(valid), .ready(ready), .overflow(overflow),
        .dropped(dropped), .busy(busy)
    );

    freq_meter #(.CNT_W(4), .SYNC_STAGES(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .en(en), .tick(tick), .sig_in(sig_in),
        .result(result4), .valid(valid4), .ready(ready), .overflow(overflow4),
        .dropped(dropped4), .busy(busy4)
    );

    always #5 clk = ~clk;

    typedef struct {
        int t_per;
        int s_per;
        int edges;
    } vec_t;

    vec_t vecs[5];

    int pass_cnt  = 0;
    int total_cnt = 0;
    bit gen_on = 1'b0;
    bit cap_on = 1'b0;
    int cur_t, next_t, cur_p, next_p, tcnt, pcnt;
    int tick_count = 0;
    int res_q[$];
    int ovf_q[$];
    int res4_q[$];
    int ovf4_q[$];

    task automatic check(input string name, input longint actual, input longint expected);
        total_cnt++;
        if (actual == expected) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // One clock: drive generated inputs, capture a handshake, advance to negedge+1
    task automatic step();
        if (gen_on) begin
            if (tcnt == cur_t - 1) begin
                tick  = 1'b1;
                tcnt  = 0;
                cur_t = next_t;
                if (cur_p != next_p) begin
                    cur_p = next_p;
                    pcnt  = 0;
                end
            end else begin
                tick = 1'b0;
                tcnt++;
            end
            sig_in = (pcnt < cur_p / 2);
            pcnt   = (pcnt == cur_p - 1) ? 0 : pcnt + 1;
        end
        if (tick) tick_count++;
        if (cap_on && valid && ready) begin
            res_q.push_back(int'(result));
            ovf_q.push_back(int'(overflow));
        end
        if (cap_on && valid4 && ready) begin
            res4_q.push_back(int'(result4));
            ovf4_q.push_back(int'(overflow4));
        end
        @(negedge clk);
        #1;
    endtask

    task automatic gen_restart(input int t, input int p);
        cur_t  = t;
        next_t = t;
        cur_p  = p;
        next_p = p;
        tcnt   = 0;
        pcnt   = 0;
        gen_on = 1'b1;
    endtask

    task automatic clear_q();
        res_q.delete();
        ovf_q.delete();
        res4_q.delete();
        ovf4_q.delete();
    endtask

    task automatic run_until_results(input int n, input int budget, input string name);
        int c;
        c = 0;
        while (res_q.size() < n && c < budget) begin
            step();
            c++;
        end
        check(name, res_q.size(), n);
    endtask

    task automatic run_until_ticks(input int n, input int budget, input string name);
        int c;
        c = 0;
        while (tick_count < n && c < budget) begin
            step();
            c++;
        end
        check(name, tick_count, n);
    endtask

    task automatic pulse();
        sig_in = 1'b1; step(); step();
        sig_in = 1'b0; step(); step();
    endtask

    function automatic int sat4(input int n);
        return (n > 15) ? 15 : n;
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, t0, n;

        vecs[0] = '{100, 10, 10};
        vecs[1] = '{200, 4, 50};
        vecs[2] = '{200, 25, 8};
        vecs[3] = '{60, 5, 12};
        vecs[4] = '{30, 6, 5};

        rst_n = 1'b0; en = 1'b0; tick = 1'b0; sig_in = 1'b0; ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("reset result", result, 0);
        check("reset valid", valid, 0);
        check("reset overflow", overflow, 0);
        check("reset dropped", dropped, 0);
        check("reset busy", busy, 0);
        rst_n = 1'b1;
        step(); step();
        check("idle busy with en low", busy, 0);

        // Table: each row reconfigures tick/signal periods in one continuous session
        clear_q();
        cap_on = 1'b1;
        gen_restart(vecs[0].t_per, vecs[0].s_per);
        en = 1'b1;
        for (int v = 0; v < 5; v++) begin
            if (v > 0) begin
                next_t = vecs[v].t_per;
                next_p = vecs[v].s_per;
            end
            base = res_q.size();
            run_until_results(base + 4, 1200, $sformatf("vec%0d window count", v));
            n = vecs[v].edges * EM;
            for (int k = 2; k < 4; k++) begin
                if (res_q.size() > base + k && res4_q.size() > base + k) begin
                    check($sformatf("vec%0d w%0d result32", v, k), res_q[base + k], n);
                    check($sformatf("vec%0d w%0d overflow32", v, k), ovf_q[base + k], 0);
                    check($sformatf("vec%0d w%0d result4", v, k), res4_q[base + k], sat4(n));
                    check($sformatf("vec%0d w%0d overflow4", v, k), ovf4_q[base + k], (n > 15) ? 1 : 0);
                end
            end
        end

        // Backpressure: two window ends without ready, counts 10 then 12
        en = 1'b0; step(); step();
        cap_on = 1'b0; ready = 1'b0;
        gen_restart(100, 10);
        t0 = tick_count;
        en = 1'b1;
        run_until_ticks(t0 + 1, 250, "bp arm tick");
        next_t = 120;
        run_until_ticks(t0 + 3, 400, "bp window ticks");
        check("bp result overwritten", result, 12 * EM);
        check("bp valid held", valid, 1);
        check("bp dropped set", dropped, 1);
        check("bp overflow", overflow, 0);
        ready = 1'b1; step(); ready = 1'b0;
        check("bp valid cleared", valid, 0);
        repeat (5) step();
        check("bp dropped sticky", dropped, 1);
        en = 1'b0; step(); step();
        check("bp dropped kept in idle", dropped, 1);
        check("bp busy idle", busy, 0);
        en = 1'b1; step();
        check("bp dropped cleared on enable", dropped, 0);
        check("bp busy arm", busy, 1);

        // Boundary: sixth rising edge reaches the counter on the closing tick cycle
        en = 1'b0; step(); step();
        gen_on = 1'b0; tick = 1'b0; sig_in = 1'b0; ready = 1'b1;
        clear_q(); cap_on = 1'b1;
        en = 1'b1;
        repeat (4) step();
        tick = 1'b1; step(); tick = 1'b0;
        repeat (5) pulse();
        repeat (4) step();
        sig_in = 1'b1; step(); step();
        tick = 1'b1; step(); tick = 1'b0;
        sig_in = 1'b0; step();
        repeat (3) pulse();
        repeat (4) step();
        tick = 1'b1; step(); tick = 1'b0;
        step(); step();
        check("boundary result count", res_q.size(), 2);
        if (res_q.size() >= 2) begin
            check("boundary window", res_q[0], 5 * EM + 1);
            check("boundary next window", res_q[1], 3 * EM + (EM - 1));
            check("boundary overflow", ovf_q[0], 0);
        end

        // Enable abort midway through a window holding 7 edges
        en = 1'b0; step(); step();
        clear_q();
        gen_restart(100, 10);
        t0 = tick_count;
        en = 1'b1;
        run_until_ticks(t0 + 1, 250, "abort arm tick");
        repeat (70) step();
        en = 1'b0;
        check("abort busy before", busy, 1);
        step();
        check("abort busy after", busy, 0);
        repeat (5) step();
        check("abort no result", res_q.size(), 0);
        en = 1'b1;
        run_until_ticks(tick_count + 1, 250, "abort rearm tick");
        repeat (3) step();
        check("abort no result after arm", res_q.size(), 0);
        run_until_results(1, 250, "abort full window count");
        if (res_q.size() >= 1) check("abort full window", res_q[0], 10 * EM);

        // Asynchronous reset in the middle of a window with a held result
        ready = 1'b0;
        run_until_ticks(tick_count + 1, 250, "rst prep tick");
        repeat (30) step();
        rst_n = 1'b0;
        #1;
        check("rst mid result", result, 0);
        check("rst mid valid", valid, 0);
        check("rst mid dropped", dropped, 0);
        check("rst mid busy", busy, 0);
        repeat (3) step();
        rst_n = 1'b1; ready = 1'b1;
        clear_q();
        t0 = tick_count;
        run_until_ticks(t0 + 1, 250, "rst rearm tick");
        repeat (3) step();
        check("rst no result after arm", res_q.size(), 0);
        check("rst busy rearmed", busy, 1);
        run_until_results(1, 250, "rst full window count");
        if (res_q.size() >= 1) check("rst full window", res_q[0], 10 * EM);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
